bus_slave_mem: RTL and testbench



---
 rtl/bus_slave_mem_pkg.sv | 15 +
 rtl/bus_slave_ram.sv | 22 ++
 rtl/bus_slave_mem.sv | 138 +++++++++++++
 tb/tb_bus_slave_mem.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bus_slave_mem_pkg.sv
// Shared constants and types for the memory-backed bus slave.
package bus_slave_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int          WAIT_CNT_W = 4;
  localparam int          DEF_DATA_W = 32;
  localparam logic [7:0]  SLV0_BASE  = 8'h00;
  localparam logic [7:0]  SLV1_BASE  = 8'h70;

endpackage

// File: rtl/bus_slave_ram.sv
// Word array with one synchronous write port and one asynchronous read port.
module bus_slave_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_slave_mem.sv
// Single-beat bus slave with programmable wait states and one-cycle ack.
// BUS_SLAVE_WP_EN adds a write-protect input (wp) and an error flag (s_err).
module bus_slave_mem
  import bus_slave_mem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
`ifdef BUS_SLAVE_WP_EN
  input  logic              wp,
  output logic              s_err,
`endif
  output logic [DATA_W-1:0] s_dout,
  output logic              s_ack
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYC == 0) ? '0 : WAIT_CNT_W'(WAIT_CYC - 1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       din_q, din_d;
  logic                    ack_q, ack_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    go_ack;
  logic                    wp_blk;
  logic                    ram_we;
  logic [DATA_W-1:0]       rd_data;

`ifdef BUS_SLAVE_WP_EN
  logic wp_q, wp_d, err_q, err_d;
  assign wp_blk = wp_d;
  assign s_err  = err_q;
`else
  assign wp_blk = 1'b0;
`endif

  // The *_d transfer fields equal the live inputs when WAIT_CYC=0 jumps
  // straight to ACK, so the RAM ports always see the transfer being acked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    go_ack  = 1'b0;
`ifdef BUS_SLAVE_WP_EN
    wp_d    = wp_q;
`endif
    case (state_q)
      IDLE: if (s_sel) begin
        wr_d   = s_wr;
        addr_d = s_addr;
        din_d  = s_din;
`ifdef BUS_SLAVE_WP_EN
        wp_d   = wp;
`endif
        if (WAIT_CYC == 0) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (!s_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d  = go_ack;
    dout_d = (go_ack && !wr_d) ? rd_data : '0;
`ifdef BUS_SLAVE_WP_EN
    err_d  = go_ack && wr_d && wp_d;
`endif
  end

  assign ram_we = go_ack && wr_d && !wp_blk && !reset;

  bus_slave_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_d),
    .wdata (din_d),
    .raddr (addr_d),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
`ifdef BUS_SLAVE_WP_EN
      wp_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
`ifdef BUS_SLAVE_WP_EN
      wp_q    <= wp_d;
      err_q   <= err_d;
`endif
    end
  end

  assign s_ack  = ack_q;
  assign s_dout = dout_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Randomized bench: three slaves (WAIT_CYC 0, 1, 3) against a transfer-level model.
module tb_bus_slave_mem;

  logic             clk = 1'b0;
  logic [2:0]       rst;
  logic [2:0]       sel;
  logic [2:0]       wr_v;
  logic [2:0][8:0]  addr;
  logic [2:0][31:0] din;
  logic [2:0][31:0] dout;
  logic [2:0]       ack;
`ifdef BUS_SLAVE_WP_EN
  logic [2:0]       wp;
  logic [2:0]       err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ack_at [3];
  logic [31:0] model [3][512];
  bit          known [3][512];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WCG = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    bus_slave_mem #(.ADDR_W(9), .DATA_W(32), .WAIT_CYC(WCG)) u_dut (
      .clk    (clk),
      .reset  (rst[g]),
      .s_sel  (sel[g]),
      .s_wr   (wr_v[g]),
      .s_addr (addr[g]),
      .s_din  (din[g]),
`ifdef BUS_SLAVE_WP_EN
      .wp     (wp[g]),
      .s_err  (err[g]),
`endif
      .s_dout (dout[g]),
      .s_ack  (ack[g])
    );
  end

  function automatic int wc(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic xfer(int k, bit wr, logic [8:0] a, logic [31:0] d,
                      bit wpv, int abort_n, bit keep);
    int n;
    bit got;
    sel[k] = 1'b1; wr_v[k] = wr; addr[k] = a; din[k] = d;
`ifdef BUS_SLAVE_WP_EN
    wp[k] = wpv;
`endif
    if (abort_n > 0) begin
      repeat (abort_n) begin
        @(posedge clk); @(negedge clk);
        chk("abort_noack_pre", ack[k], 0);
      end
      sel[k] = 1'b0;
      repeat (wc(k) + 2) begin
        @(posedge clk); @(negedge clk);
        chk("abort_noack_post", ack[k], 0);
      end
      return;
    end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = ack[k];
      if (!got) chk("dout_zero_wait", dout[k], 0);
    end
    chk("ack_latency", n, wc(k) + 1);
    ack_at[k] = cyc;
    if (got) begin
      if (wr) chk("dout_zero_write", dout[k], 0);
      else    chk("read_data", dout[k], model[k][a]);
`ifdef BUS_SLAVE_WP_EN
      chk("err_flag", err[k], 32'(wr && wpv));
`endif
      if (wr && !wpv) begin
        model[k][a] = d;
        known[k][a] = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      chk("ack_one_cycle", ack[k], 0);
      chk("dout_zero_after", dout[k], 0);
    end
    if (!keep) sel[k] = 1'b0;
  endtask

  initial begin
    int p0;
    rst = '1; sel = '0; wr_v = '0; addr = '0; din = '0;
`ifdef BUS_SLAVE_WP_EN
    wp = '0;
`endif
    for (int k = 0; k < 3; k++) for (int i = 0; i < 512; i++) known[k][i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ack", ack[k], 0);
      chk("reset_dout", dout[k], 0);
    end
    rst = '0;
    @(negedge clk);

    // Zero wait states at the top of the slave's range
    xfer(0, 1, 9'h1FF, 32'h12345678, 0, 0, 0);
    xfer(0, 0, 9'h1FF, 32'h0, 0, 0, 0);

    // Reset mid-WAIT discards the pending write
    xfer(1, 1, 9'h005, 32'h11111111, 0, 0, 0);
    sel[1] = 1'b1; wr_v[1] = 1'b1; addr[1] = 9'h005; din[1] = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_ack", ack[1], 0);
    chk("rst_mid_dout", dout[1], 0);
    rst[1] = 1'b0; sel[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_no_late_ack", ack[1], 0);
    end
    xfer(1, 0, 9'h005, 32'h0, 0, 0, 0);

    // Three wait states, read and aborted write
    xfer(2, 1, 9'h010, 32'h00000000, 0, 0, 0);
    xfer(2, 0, 9'h010, 32'h0, 0, 0, 0);
    xfer(2, 1, 9'h010, 32'hA5A5A5A5, 0, 2, 0);
    xfer(2, 0, 9'h010, 32'h0, 0, 0, 0);

    // Back-to-back writes, ack spacing WAIT_CYC+2
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1, 9'(i), 32'hC0DE0000 + 32'(i), 0, 0, (i < 3));
      if (i == 0) p0 = ack_at[1];
      else begin
        chk("b2b_spacing", ack_at[1] - p0, 3);
        p0 = ack_at[1];
      end
    end
    for (int i = 0; i < 4; i++) xfer(1, 0, 9'(i), 32'h0, 0, 0, 0);

`ifdef BUS_SLAVE_WP_EN
    xfer(1, 1, 9'h020, 32'h00000BAD, 0, 0, 0);
    xfer(1, 1, 9'h020, 32'hFFFF0000, 1, 0, 0);
    xfer(1, 0, 9'h020, 32'h0, 1, 0, 0);
    xfer(1, 1, 9'h020, 32'h0000600D, 0, 0, 0);
    xfer(1, 0, 9'h020, 32'h0, 0, 0, 0);
`endif

    // Randomized traffic
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) xfer(k, 1, 9'(i), $urandom, 0, 0, 0);
    for (int it = 0; it < 80; it++) begin
      int k, ab;
      bit w, wpr;
      logic [8:0] a;
      k   = $urandom_range(0, 2);
      a   = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 31));
      w   = $urandom_range(0, 1) == 1;
      if (!known[k][a]) w = 1'b1;
      ab  = (k == 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
`ifdef BUS_SLAVE_WP_EN
      wpr = $urandom_range(0, 3) == 0;
`else
      wpr = 1'b0;
`endif
      xfer(k, w, a, $urandom, wpr, ab, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
